block_sum_sequencer: RTL and testbench
======================================

# block_sum_sequencer

Generates the per-offset Hamming-distance stream for one reference census block at a time. For each accepted block it scans every candidate offset of the search window, fetches the candidate census block, and emits one saturated 8-bit distance per offset with its coordinates and block index. It sits directly upstream of the minimum-distance finder and drives its sum/out_coords/blk_index_o/sum_valid inputs, including the scan order and inter-block gap that finder depends on.

## Interface
- blk_h, 16, reference block height (rows)
- blk_w, 16, reference block width (columns)
- search_blk_w, 64, search window width; search_blk_w - blk_w ≥ 1
- search_blk_h, 20, search window height; search_blk_h - blk_h ≥ 1
- blk_size, blk_h*blk_w, census bits per block

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- blk_valid  in  1  reference block offered
- blk_ready  out  1  block accepted when blk_valid & blk_ready
- blk_index_i  in  16  index of offered block
- ref_blk  in  blk_size  reference census bits
- cand_rd  out  1  candidate fetch request
- cand_coords  out  16  {v[7:0], h[7:0]} of requested candidate
- cand_data  in  blk_size  candidate census bits, valid exactly 1 cycle after cand_rd
- sum  out  8  saturated Hamming distance
- out_coords  out  16  {v[7:0], h[7:0]} belonging to sum
- blk_index_o  out  16  index of block being scanned
- sum_valid  out  1  sum/out_coords/blk_index_o valid this cycle
- busy  out  1  high in any state except IDLE

## Operation
- VMAX = search_blk_h - blk_h - 1, HMAX = search_blk_w - blk_w - 1 (defaults 3, 47; 192 offsets).
- States: IDLE, SCAN, DRAIN, GAP.
- IDLE: blk_ready = 1. On handshake latch ref_blk, blk_index_i; v←0, h←HMAX; → SCAN.
- SCAN: cand_rd = 1 every cycle, cand_coords = {v,h}. Order: h counts down HMAX..0, then v increments, h reloads HMAX. Last issue {VMAX,0} → DRAIN.
- Pipeline (no stalls): P1 registers cand_data XOR ref and coords; P2 registers 16 partial popcounts; P3 registers final sum = min(popcount, 255) with sum_valid.
- DRAIN: 3 cycles (pipeline empty) → GAP.
- GAP: 2 cycles, sum_valid low → IDLE. Guarantees ≥2 idle cycles after last sum so the finder's valid/clear sequence completes before the next block.
- Last sum of each block always carries out_coords = {VMAX, 8'h00}; exactly (VMAX+1)*(HMAX+1) sum_valid pulses per block.
- blk_index_o constant for the whole block, updated at acceptance.
- No downstream backpressure; sum stream is never interrupted within a block.

## Timing
- Reset values: blk_ready 0, cand_rd 0, cand_coords 0, sum 0, out_coords 0, blk_index_o 0, sum_valid 0, busy 0; state IDLE. blk_ready goes 1 on first clk edge after reset_n release.
- Acceptance at edge T: first cand_rd in cycle T+1, its sum_valid at T+4 (3-cycle cand_rd→sum_valid latency).
- Per block: 1 accept + N issue + 3 drain + 2 gap cycles; next acceptance earliest N+6 cycles after previous.
- blk_valid held high continuously: blocks accepted back-to-back at that rate; blk_ready low outside IDLE.
- Reset mid-operation: immediate clear of all outputs and pipeline; no partial-block sums emitted after release.
- Saturation: popcount 255..blk_size all report 255.

## Test plan
- Reset: hold reset_n low, drive blk_valid=1 -> all outputs 0; after release blk_ready=1 next cycle.
- Single block, ref all 0, candidate model returns popcount = h + 4v -> 192 pulses, first out_coords 0x002F sum 47, last 0x0300 sum 12, blk_index_o = blk_index_i throughout, sum_valid first at accept+4.
- Equal data: cand_data = ref_blk for all offsets -> every sum 0.
- Saturation: ref all 0, cand_data all 1 (256 bits) -> every sum 255; popcount 200 -> sum 200.
- Back-to-back: blk_valid held high, indices 0x0001, 0x0002 -> ≥2 cycles sum_valid low between 0x0300 of block 1 and 0x002F of block 2; blk_index_o switches only at second acceptance.
- Reset after 50th cand_rd -> outputs 0 during reset, no sum_valid after release until new block; new block restarts at 0x002F.

Source files
------------

// File: rtl/block_sum_sequencer_if.sv
// Bundle of the block handshake, candidate fetch and distance stream signals of block_sum_sequencer.
// slave  : the sequencer's view (accepts blocks, issues fetches, emits sums).
// master : the environment's view (offers blocks, answers fetches, consumes sums).
interface block_sum_sequencer_if #(
    parameter int blk_size = 256
);
    // reference block offer
    logic                blk_valid;
    logic                blk_ready;
    logic [15:0]         blk_index_i;
    logic [blk_size-1:0] ref_blk;
    // candidate fetch: data answers exactly one cycle after cand_rd
    logic                cand_rd;
    logic [15:0]         cand_coords;
    logic [blk_size-1:0] cand_data;
    // distance stream towards the minimum-distance finder
    logic [7:0]          sum;
    logic [15:0]         out_coords;
    logic [15:0]         blk_index_o;
    logic                sum_valid;
    logic                busy;

    modport slave (
        input  blk_valid, blk_index_i, ref_blk, cand_data,
        output blk_ready, cand_rd, cand_coords, sum, out_coords, blk_index_o, sum_valid, busy
    );

    modport master (
        output blk_valid, blk_index_i, ref_blk, cand_data,
        input  blk_ready, cand_rd, cand_coords, sum, out_coords, blk_index_o, sum_valid, busy
    );
endinterface

// File: rtl/block_sum_sequencer.sv
// Purpose : scans every search offset of one reference census block and emits a saturated Hamming distance per offset.
// Latency : cand_rd -> sum_valid 3 cycles after the fetch is sampled (accept edge + 4); N + 6 cycles per block.
// Backpr. : blk_ready only in IDLE; no downstream backpressure, the sum stream is never interrupted within a block.
// Ports   : clk, reset_n (async active-low); bus = block_sum_sequencer_if.slave (block offer, candidate fetch, sum stream, busy).
module block_sum_sequencer #(
    parameter int blk_h        = 16,
    parameter int blk_w        = 16,
    parameter int search_blk_w = 64,
    parameter int search_blk_h = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    block_sum_sequencer_if.slave bus
);
    localparam int blk_size = blk_h * blk_w;
    localparam int VMAX     = search_blk_h - blk_h - 1;
    localparam int HMAX     = search_blk_w - blk_w - 1;
    localparam logic [7:0] VMAX_C = 8'(VMAX);
    localparam logic [7:0] HMAX_C = 8'(HMAX);

    // popcount split into 16 equal slices, summed in the final stage
    localparam int N_PART  = 16;
    localparam int PART_W  = blk_size / N_PART;
    localparam int PART_CW = $clog2(PART_W + 1);

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] h;
    } coords_t;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, GAP} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cnt_q;          // cycles spent in the current state
    logic                blk_ready_q;
    coords_t             pos_q;          // offset being issued
    logic [blk_size-1:0] ref_q;
    logic [15:0]         idx_q;

    logic                accept;
    logic                last_issue;

    logic                cand_rd_c;
    logic                busy_c;
    coords_t             coords_c;

    // pipeline
    logic                vld0_q, vld1_q, vld2_q;
    coords_t             co0_q, co1_q, co2_q;
    logic [blk_size-1:0] xor_q;
    logic [PART_CW-1:0]  part_q [N_PART];
    logic [15:0]         total;
    logic [7:0]          sum_q;
    coords_t             out_coords_q;
    logic                sum_valid_q;

    assign accept     = (state == IDLE) && blk_ready_q && bus.blk_valid;
    assign last_issue = (state == SCAN) && (pos_q.v == VMAX_C) && (pos_q.h == 8'd0);

    // ------------------------------------------------------------------
    // State register. blk_ready is registered so it stays low in reset and
    // rises on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt_q       <= 2'd0;
            blk_ready_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt_q       <= (state_nxt != state) ? 2'd0 : cnt_q + 2'd1;
            blk_ready_q <= (state_nxt == IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. DRAIN lets the 3-deep pipeline empty, GAP adds two
    // more quiet cycles so the finder can close out the block.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)          state_nxt = SCAN;
            SCAN:    if (last_issue)      state_nxt = DRAIN;
            DRAIN:   if (cnt_q == 2'd2)   state_nxt = GAP;
            GAP:     if (cnt_q == 2'd1)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cand_rd_c = 1'b0;
        busy_c    = 1'b1;
        coords_c  = '0;
        case (state)
            IDLE:    busy_c = 1'b0;
            SCAN: begin
                cand_rd_c = 1'b1;
                coords_c  = pos_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Block latch and scan position: h counts down, v counts up.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= '0;
            ref_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            pos_q.v <= 8'd0;
            pos_q.h <= HMAX_C;
            ref_q   <= bus.ref_blk;
            idx_q   <= bus.blk_index_i;
        end else if ((state == SCAN) && !last_issue) begin
            if (pos_q.h == 8'd0) begin
                pos_q.h <= HMAX_C;
                pos_q.v <= pos_q.v + 8'd1;
            end else begin
                pos_q.h <= pos_q.h - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Distance pipeline. Stage 0 only aligns the request with the data that
    // answers it one cycle later; P1 XOR, P2 partial popcounts, P3 sum.
    // ------------------------------------------------------------------
    always_comb begin
        total = '0;
        for (int i = 0; i < N_PART; i++) begin
            total = total + 16'(part_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
            vld2_q       <= 1'b0;
            co0_q        <= '0;
            co1_q        <= '0;
            co2_q        <= '0;
            xor_q        <= '0;
            for (int i = 0; i < N_PART; i++) begin
                part_q[i] <= '0;
            end
            sum_q        <= '0;
            out_coords_q <= '0;
            sum_valid_q  <= 1'b0;
        end else begin
            vld0_q <= cand_rd_c;
            co0_q  <= coords_c;

            vld1_q <= vld0_q;
            co1_q  <= co0_q;
            xor_q  <= bus.cand_data ^ ref_q;

            vld2_q <= vld1_q;
            co2_q  <= co1_q;
            for (int i = 0; i < N_PART; i++) begin
                part_q[i] <= PART_CW'($countones(xor_q[i*PART_W +: PART_W]));
            end

            sum_valid_q <= vld2_q;
            if (vld2_q) begin
                sum_q        <= (total > 16'd255) ? 8'hFF : total[7:0];
                out_coords_q <= co2_q;
            end
        end
    end

    assign bus.blk_ready   = blk_ready_q;
    assign bus.cand_rd     = cand_rd_c;
    assign bus.cand_coords = coords_c;
    assign bus.sum         = sum_q;
    assign bus.out_coords  = out_coords_q;
    assign bus.blk_index_o = idx_q;
    assign bus.sum_valid   = sum_valid_q;
    assign bus.busy        = busy_c;
endmodule

// File: tb/tb_block_sum_sequencer.sv
// Self-checking bench for block_sum_sequencer: a candidate memory model answers fetches,
// a monitor records the sum stream, and each scenario task compares it to a reference scan.
module tb_block_sum_sequencer;
    localparam int BS   = 256;
    localparam int VMAX = 3;
    localparam int HMAX = 47;
    localparam int N    = (VMAX + 1) * (HMAX + 1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    block_sum_sequencer_if #(.blk_size(BS)) ifc ();

    block_sum_sequencer #(
        .blk_h(16), .blk_w(16), .search_blk_w(64), .search_blk_h(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rd_count = 0;

    // candidate source: 0 = popcount h+4v, 1 = equal to ref, 2 = all ones, 3 = table
    int          cur_mode = 0;
    logic [BS-1:0] cur_ref = '0;
    logic [BS-1:0] cand_tab [VMAX+1][HMAX+1];

    // monitor records
    logic [7:0]  s_sum [$];
    logic [15:0] s_co  [$];
    logic [15:0] s_idx [$];
    int          s_edge[$];
    int          a_edge[$];
    logic [15:0] a_prev_idx[$];

    // expected stream
    logic [7:0]  e_sum [$];
    logic [15:0] e_co  [$];

    function automatic logic [BS-1:0] low_ones(input int k);
        logic [BS-1:0] m;
        for (int i = 0; i < BS; i++) m[i] = (i < k);
        return m;
    endfunction

    function automatic logic [BS-1:0] rand_vec();
        logic [BS-1:0] r;
        for (int i = 0; i < BS/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BS-1:0] cand_of(input int v, input int h);
        case (cur_mode)
            0:       return low_ones(h + 4*v);
            1:       return cur_ref;
            2:       return '1;
            default: return cand_tab[v][h];
        endcase
    endfunction

    // Reference scan: v ascending, h descending, saturated Hamming distance.
    function automatic void build_exp();
        int c;
        e_sum.delete();
        e_co.delete();
        for (int v = 0; v <= VMAX; v++) begin
            for (int h = HMAX; h >= 0; h--) begin
                c = $countones(cur_ref ^ cand_of(v, h));
                e_sum.push_back((c > 255) ? 8'd255 : 8'(c));
                e_co.push_back({8'(v), 8'(h)});
            end
        end
    endfunction

    function automatic void clear_mon();
        s_sum.delete(); s_co.delete(); s_idx.delete(); s_edge.delete();
        a_edge.delete(); a_prev_idx.delete();
    endfunction

    // Monitor: values at negedge n reflect posedge n-1; acceptance seen here happens at posedge n.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (ifc.cand_rd) rd_count++;
            if (ifc.blk_valid && ifc.blk_ready) begin
                a_edge.push_back(cyc);
                a_prev_idx.push_back(ifc.blk_index_o);
            end
            if (ifc.sum_valid) begin
                s_sum.push_back(ifc.sum);
                s_co.push_back(ifc.out_coords);
                s_idx.push_back(ifc.blk_index_o);
                s_edge.push_back(cyc - 1);
            end
        end
    end

    // Candidate memory: answers one cycle after the request, garbage otherwise.
    initial begin
        logic        rd;
        logic [15:0] co;
        ifc.cand_data = '0;
        forever begin
            @(negedge clk);
            rd = ifc.cand_rd;
            co = ifc.cand_coords;
            @(posedge clk);
            #1;
            ifc.cand_data = rd ? cand_of(int'(co[15:8]), int'(co[7:0])) : rand_vec();
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d fails=%0d)", checks, fails);
        $fatal(1, "watchdog");
    end

    task automatic send_block(input logic [15:0] idx, input bit keep);
        int n = 0;
        @(posedge clk); #1;
        ifc.blk_valid   = 1'b1;
        ifc.blk_index_i = idx;
        ifc.ref_blk     = cur_ref;
        @(negedge clk); #1;
        while (!ifc.blk_ready && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if (!keep) ifc.blk_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int k = 0;
        while (s_sum.size() < n && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (12) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ifc.blk_valid   = 1'b1;
        ifc.blk_index_i = 16'hBEEF;
        ifc.ref_blk     = rand_vec();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ifc.blk_ready, ifc.cand_rd, ifc.cand_coords, ifc.sum, ifc.out_coords,
             ifc.blk_index_o, ifc.sum_valid, ifc.busy} !== 59'd0)
            begin fails++; $display("FAIL reset_outputs: got rdy=%b rd=%b cc=%h sum=%h oc=%h idx=%h sv=%b busy=%b, want all 0",
                ifc.blk_ready, ifc.cand_rd, ifc.cand_coords, ifc.sum, ifc.out_coords, ifc.blk_index_o, ifc.sum_valid, ifc.busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (ifc.blk_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b want 0", ifc.blk_ready); end
        ifc.blk_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ifc.blk_ready !== 1'b1) begin fails++; $display("FAIL ready_after_release: got %b want 1", ifc.blk_ready); end
        checks++;
        if (ifc.busy !== 1'b0) begin fails++; $display("FAIL busy_after_release: got %b want 0", ifc.busy); end
        clear_mon();
    endtask

    task automatic test_single_block();
        logic [15:0] idx = 16'($urandom);
        int lat;
        cur_mode = 0; cur_ref = '0;
        build_exp(); clear_mon();
        send_block(idx, 1'b0);
        wait_pulses(N);
        checks++;
        if (s_sum.size() != N) begin fails++; $display("FAIL single_count: got %0d want %0d", s_sum.size(), N); end
        for (int i = 0; i < N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== e_sum[i] || s_co[i] !== e_co[i] || s_idx[i] !== idx) begin
                fails++;
                $display("FAIL single_pulse[%0d]: got sum=%0d co=%h idx=%h want sum=%0d co=%h idx=%h",
                    i, s_sum[i], s_co[i], s_idx[i], e_sum[i], e_co[i], idx);
            end
        end
        checks++;
        if (s_sum.size() < 1 || s_co[0] !== 16'h002F || s_sum[0] !== 8'd47)
            begin fails++; $display("FAIL single_first: got co=%h sum=%0d want 002f/47", (s_co.size() > 0) ? s_co[0] : 16'hxxxx, (s_sum.size() > 0) ? s_sum[0] : 8'hxx); end
        checks++;
        if (s_sum.size() < N || s_co[N-1] !== 16'h0300 || s_sum[N-1] !== 8'd12)
            begin fails++; $display("FAIL single_last: got co=%h sum=%0d want 0300/12", (s_co.size() >= N) ? s_co[N-1] : 16'hxxxx, (s_sum.size() >= N) ? s_sum[N-1] : 8'hxx); end
        lat = (a_edge.size() > 0 && s_edge.size() > 0) ? s_edge[0] - a_edge[0] : -1;
        checks++;
        if (lat != 4) begin fails++; $display("FAIL single_latency: got %0d want 4", lat); end
        checks++;
        if (s_edge.size() < N || s_edge[N-1] - s_edge[0] != N - 1)
            begin fails++; $display("FAIL single_contiguous: got span %0d want %0d", (s_edge.size() >= N) ? s_edge[N-1] - s_edge[0] : -1, N - 1); end
        checks++;
        if (ifc.busy !== 1'b0 || ifc.blk_ready !== 1'b1)
            begin fails++; $display("FAIL single_idle: got busy=%b rdy=%b want 0/1", ifc.busy, ifc.blk_ready); end
    endtask

    task automatic test_equal();
        logic [15:0] idx = 16'($urandom);
        cur_mode = 1; cur_ref = rand_vec();
        build_exp(); clear_mon();
        send_block(idx, 1'b0);
        wait_pulses(N);
        checks++;
        if (s_sum.size() != N) begin fails++; $display("FAIL equal_count: got %0d want %0d", s_sum.size(), N); end
        for (int i = 0; i < N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== e_sum[i] || s_co[i] !== e_co[i] || s_idx[i] !== idx) begin
                fails++;
                $display("FAIL equal_pulse[%0d]: got sum=%0d co=%h idx=%h want sum=%0d co=%h idx=%h",
                    i, s_sum[i], s_co[i], s_idx[i], e_sum[i], e_co[i], idx);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] idx = 16'($urandom);
        logic [7:0]  want4 [4] = '{8'd200, 8'd255, 8'd255, 8'd254};
        // all ones against zero reference: every offset saturates
        cur_mode = 2; cur_ref = '0;
        build_exp(); clear_mon();
        send_block(idx, 1'b0);
        wait_pulses(N);
        checks++;
        if (s_sum.size() != N) begin fails++; $display("FAIL sat_ones_count: got %0d want %0d", s_sum.size(), N); end
        for (int i = 0; i < N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== 8'd255 || s_co[i] !== e_co[i]) begin
                fails++;
                $display("FAIL sat_ones[%0d]: got sum=%0d co=%h want 255 co=%h", i, s_sum[i], s_co[i], e_co[i]);
            end
        end
        // random candidates with exact popcounts 200/255/256/254 on the first four offsets
        cur_mode = 3; cur_ref = rand_vec();
        for (int v = 0; v <= VMAX; v++)
            for (int h = 0; h <= HMAX; h++)
                cand_tab[v][h] = rand_vec();
        cand_tab[0][HMAX]   = cur_ref ^ low_ones(200);
        cand_tab[0][HMAX-1] = cur_ref ^ low_ones(255);
        cand_tab[0][HMAX-2] = cur_ref ^ low_ones(256);
        cand_tab[0][HMAX-3] = cur_ref ^ low_ones(254);
        idx = 16'($urandom);
        build_exp(); clear_mon();
        send_block(idx, 1'b0);
        wait_pulses(N);
        checks++;
        if (s_sum.size() != N) begin fails++; $display("FAIL sat_rand_count: got %0d want %0d", s_sum.size(), N); end
        for (int i = 0; i < 4 && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== want4[i]) begin fails++; $display("FAIL sat_edge[%0d]: got %0d want %0d", i, s_sum[i], want4[i]); end
        end
        for (int i = 0; i < N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== e_sum[i] || s_co[i] !== e_co[i] || s_idx[i] !== idx) begin
                fails++;
                $display("FAIL sat_rand[%0d]: got sum=%0d co=%h idx=%h want sum=%0d co=%h idx=%h",
                    i, s_sum[i], s_co[i], s_idx[i], e_sum[i], e_co[i], idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        int span;
        cur_mode = 0; cur_ref = '0;
        build_exp(); clear_mon();
        send_block(16'h0001, 1'b1);
        send_block(16'h0002, 1'b0);
        wait_pulses(2 * N);
        checks++;
        if (s_sum.size() != 2 * N) begin fails++; $display("FAIL b2b_count: got %0d want %0d", s_sum.size(), 2 * N); end
        for (int i = 0; i < 2 * N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== e_sum[i % N] || s_co[i] !== e_co[i % N] || s_idx[i] !== ((i < N) ? 16'h0001 : 16'h0002)) begin
                fails++;
                $display("FAIL b2b_pulse[%0d]: got sum=%0d co=%h idx=%h want sum=%0d co=%h idx=%0d",
                    i, s_sum[i], s_co[i], s_idx[i], e_sum[i % N], e_co[i % N], (i < N) ? 1 : 2);
            end
        end
        gap = (s_edge.size() > N) ? s_edge[N] - s_edge[N-1] - 1 : -1;
        checks++;
        if (gap < 2) begin fails++; $display("FAIL b2b_gap: got %0d idle cycles want >= 2", gap); end
        span = (a_edge.size() >= 2) ? a_edge[1] - a_edge[0] : -1;
        checks++;
        if (span != N + 6) begin fails++; $display("FAIL b2b_accept_spacing: got %0d want %0d", span, N + 6); end
        checks++;
        if (a_prev_idx.size() < 2 || a_prev_idx[1] !== 16'h0001)
            begin fails++; $display("FAIL b2b_index_hold: got %h want 0001", (a_prev_idx.size() >= 2) ? a_prev_idx[1] : 16'hxxxx); end
    endtask

    task automatic test_reset_mid();
        int rd0;
        int k = 0;
        cur_mode = 0; cur_ref = '0;
        clear_mon();
        rd0 = rd_count;
        send_block(16'h0055, 1'b0);
        while (rd_count - rd0 < 50 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({ifc.blk_ready, ifc.cand_rd, ifc.cand_coords, ifc.sum, ifc.out_coords,
             ifc.blk_index_o, ifc.sum_valid, ifc.busy} !== 59'd0)
            begin fails++; $display("FAIL midreset_outputs: got rdy=%b rd=%b cc=%h sum=%h oc=%h idx=%h sv=%b busy=%b, want all 0",
                ifc.blk_ready, ifc.cand_rd, ifc.cand_coords, ifc.sum, ifc.out_coords, ifc.blk_index_o, ifc.sum_valid, ifc.busy); end
        repeat (3) @(negedge clk);
        clear_mon();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (s_sum.size() != 0 || ifc.busy !== 1'b0)
            begin fails++; $display("FAIL midreset_quiet: got %0d sums busy=%b want 0/0", s_sum.size(), ifc.busy); end
        build_exp(); clear_mon();
        send_block(16'h0066, 1'b0);
        wait_pulses(N);
        checks++;
        if (s_sum.size() != N) begin fails++; $display("FAIL midreset_count: got %0d want %0d", s_sum.size(), N); end
        checks++;
        if (s_sum.size() < 1 || s_co[0] !== 16'h002F || s_sum[0] !== 8'd47 || s_idx[0] !== 16'h0066)
            begin fails++; $display("FAIL midreset_restart: got co=%h sum=%0d idx=%h want 002f/47/0066",
                (s_co.size() > 0) ? s_co[0] : 16'hxxxx, (s_sum.size() > 0) ? s_sum[0] : 8'hxx, (s_idx.size() > 0) ? s_idx[0] : 16'hxxxx); end
        for (int i = 0; i < N && i < s_sum.size(); i++) begin
            checks++;
            if (s_sum[i] !== e_sum[i] || s_co[i] !== e_co[i]) begin
                fails++;
                $display("FAIL midreset_pulse[%0d]: got sum=%0d co=%h want sum=%0d co=%h", i, s_sum[i], s_co[i], e_sum[i], e_co[i]);
            end
        end
    endtask

    initial begin
        ifc.blk_valid   = 1'b0;
        ifc.blk_index_i = '0;
        ifc.ref_blk     = '0;
        test_reset();
        test_single_block();
        test_equal();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
